// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared fetch-path types and constants
// Purpose: fetch queue entry layout, default reset PC, instruction size.
package cpu_defs_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int unsigned INST_BYTES       = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch_entry_t
// Purpose: DEPTH-entry queue with push/pop/clear; push while full is taken
//          only when a pop happens in the same cycle.
// Ports:   clk_i, rst_i (async active-low), push_i/wdata_i, pop_i, clear_i,
//          rdata_o (head, stale when empty), full_o, empty_o, count_o.
module fetch_fifo
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  fetch_entry_t  wdata_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output fetch_entry_t  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        full_o   = (count_q == CW'(DEPTH));
        empty_o  = (count_q == '0);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - pipelined instruction fetch with response queue
// Purpose: issues sequential PCs with up to MAX_OUTSTANDING bus requests in
//          flight, queues returned instructions with their PCs, hands them to
//          decode by valid/ready, drops stale responses after redirects and
//          emits an adel entry for a misaligned fetch address.
// Ports:   clk_i, rst_i (async active-low); flush_i/new_pc_i and
//          branch_flag_i/branch_to_addr_i redirects; inst_req_o/inst_addr_o/
//          inst_addr_ok_i/inst_data_ok_i/inst_rdata_i instruction bus;
//          valid_o/ready_i/pc_o/inst_o/adel_o decode side.
module if_fetch_queue
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_to_addr_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        adel_o
);

    localparam int unsigned QCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CRW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          halted_q, halted_d;

    logic          redirect, aligned, accept, resp, adel_fire;
    logic [31:0]   redirect_pc;
    logic [CRW-1:0] credit;

    logic          q_push, q_pop, q_clear, q_full, q_empty;
    fetch_entry_t  q_wdata, q_head;
    logic [QCW-1:0] q_count;

    logic          sh_push, sh_pop, sh_full, sh_empty;
    fetch_entry_t  sh_wdata, sh_head, resp_entry;
    logic [OW-1:0] sh_count;

    always_comb begin
        redirect    = flush_i || branch_flag_i;
        redirect_pc = flush_i ? new_pc_i : branch_to_addr_i;
        aligned     = (fetch_pc_q[1:0] == 2'b00);
        // Queue slots already spoken for: entries held plus answers still due.
        credit      = CRW'(q_count) + CRW'(out_q);
        inst_req_o  = rst_i && !redirect && !halted_q && aligned &&
                      (out_q < OW'(MAX_OUTSTANDING)) &&
                      (credit < CRW'(FIFO_DEPTH));
        inst_addr_o = fetch_pc_q;
        accept      = inst_req_o && inst_addr_ok_i;
        resp        = inst_data_ok_i && (out_q != '0);
        // The adel entry waits until every older request has drained so it
        // lands in program order behind them.
        adel_fire   = !redirect && !halted_q && !aligned &&
                      (out_q == '0) && (discard_q == '0) && !q_full;

        resp_entry      = sh_head;
        resp_entry.inst = inst_rdata_i;
        resp_entry.adel = 1'b0;

        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        discard_d  = discard_q;
        halted_d   = halted_q;
        q_push     = 1'b0;
        q_wdata    = resp_entry;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
        end
        case ({accept, resp})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        if (resp) begin
            if (discard_q != '0) begin
                discard_d = discard_q - OW'(1);
            end else begin
                q_push = 1'b1;
            end
        end else if (adel_fire) begin
            q_push   = 1'b1;
            q_wdata  = '{pc: fetch_pc_q, inst: 32'h0, adel: 1'b1};
            halted_d = 1'b1;
        end

        // Every request still in flight (including ones already marked for
        // discard) belongs to the old path; a response arriving right now is
        // dropped here and not counted again.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            discard_d  = out_q - OW'(resp);
            q_push     = 1'b0;
        end

        q_clear = redirect;
        q_pop   = valid_o && ready_i && !redirect;

        // The shadow queue is never cleared: discarded responses still pop
        // their PC so issue order stays aligned with response order.
        sh_push  = accept;
        sh_wdata = '{pc: fetch_pc_q, inst: 32'h0, adel: 1'b0};
        sh_pop   = resp;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (q_push),
        .wdata_i (q_wdata),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pc_shadow (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (sh_push),
        .wdata_i (sh_wdata),
        .pop_i   (sh_pop),
        .clear_i (1'b0),
        .rdata_o (sh_head),
        .full_o  (sh_full),
        .empty_o (sh_empty),
        .count_o (sh_count)
    );

    assign valid_o = !q_empty;
    assign pc_o    = q_empty ? 32'h0 : q_head.pc;
    assign inst_o  = q_empty ? 32'h0 : q_head.inst;
    assign adel_o  = q_empty ? 1'b0  : q_head.adel;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(q_push && q_full && !q_pop));
    a_shadow_tracks: assert property (@(posedge clk_i) disable iff (!rst_i)
        (sh_count == out_q) && (sh_empty == (out_q == '0)) &&
        !(sh_push && sh_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
    import cpu_defs_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_to_addr_i = '0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i = 1'b0;
    logic        inst_data_ok_i = 1'b0;
    logic [31:0] inst_rdata_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        adel_o;

    int checks = 0;
    int failures = 0;
    int epoch = 0;
    int req_seen = 0;
    logic bus_ready = 1'b0;
    logic resp_en = 1'b0;
    logic [31:0] exp_pc = RST_PC;

    pend_t        pend_q[$];
    fetch_entry_t sb_q[$];
    fetch_entry_t pop_log[$];
    logic [31:0]  acc_log[$];

    if_fetch_queue dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .new_pc_i         (new_pc_i),
        .branch_flag_i    (branch_flag_i),
        .branch_to_addr_i (branch_to_addr_i),
        .inst_req_o       (inst_req_o),
        .inst_addr_o      (inst_addr_o),
        .inst_addr_ok_i   (inst_addr_ok_i),
        .inst_data_ok_i   (inst_data_ok_i),
        .inst_rdata_i     (inst_rdata_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .adel_o           (adel_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] first_acc();
        return (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] first_pop_pc();
        return (pop_log.size() > 0) ? pop_log[0].pc : 32'hDEAD_DEAD;
    endfunction

    // One bus/decode cycle; called at posedge+1, returns at the next posedge+1.
    task automatic step();
        logic         acc;
        logic         redir;
        logic [31:0]  acc_addr;
        pend_t        p;
        fetch_entry_t e;
        inst_addr_ok_i = bus_ready;
        if (resp_en && pend_q.size() > 0) begin
            inst_data_ok_i = 1'b1;
            inst_rdata_i   = inst_of(pend_q[0].addr);
        end else begin
            inst_data_ok_i = 1'b0;
            inst_rdata_i   = 32'h0;
        end
        #1;
        redir = flush_i || branch_flag_i;
        if (redir) chk("req_during_redirect", 32'(inst_req_o), 32'h0);
        if (inst_req_o) req_seen++;
        acc      = inst_req_o && inst_addr_ok_i;
        acc_addr = inst_addr_o;
        if (acc) begin
            chk("fetch_addr", acc_addr, exp_pc);
            acc_log.push_back(acc_addr);
            exp_pc = exp_pc + 32'd4;
        end
        if (valid_o && ready_i) begin
            pop_log.push_back('{pc: pc_o, inst: inst_o, adel: adel_o});
            if (sb_q.size() == 0) begin
                chk("unexpected_pop_valid", 32'(valid_o), 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("head_pc", pc_o, e.pc);
                chk("head_inst", inst_o, e.inst);
                chk("head_adel", 32'(adel_o), 32'(e.adel));
            end
        end
        if (inst_data_ok_i) begin
            p = pend_q.pop_front();
            if (!redir && p.epoch == epoch)
                sb_q.push_back('{pc: p.addr, inst: inst_of(p.addr), adel: 1'b0});
        end
        if (redir) begin
            sb_q.delete();
            epoch++;
            exp_pc = flush_i ? new_pc_i : branch_to_addr_i;
            if (exp_pc[1:0] != 2'b00)
                sb_q.push_back('{pc: exp_pc, inst: 32'h0, adel: 1'b1});
        end
        @(posedge clk_i);
        #1;
        if (acc) pend_q.push_back('{addr: acc_addr, epoch: epoch});
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_req", 32'(inst_req_o), 32'h0);
        chk("rst_adel", 32'(adel_o), 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        rst_i = 1'b1;

        // Streaming: one fetch per cycle, first delivery on the third cycle
        bus_ready = 1'b1; resp_en = 1'b1; ready_i = 1'b1;
        repeat (12) step();
        chk("stream_addr0", first_acc(), 32'hBFC0_0000);
        chk("stream_addr1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_DEAD, 32'hBFC0_0004);
        chk("stream_addr2", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_DEAD, 32'hBFC0_0008);
        chk("stream_pops", 32'(pop_log.size()), 32'd10);

        // Back-pressure: exactly FIFO_DEPTH requests, one more per pop
        ready_i = 1'b0;
        flush_i = 1'b1; new_pc_i = 32'h0000_2000;
        step();
        acc_log.delete();
        repeat (12) step();
        chk("bp_accepts", 32'(acc_log.size()), 32'd4);
        chk("bp_req_held", 32'(inst_req_o), 32'h0);
        chk("bp_valid", 32'(valid_o), 32'h1);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        acc_log.delete();
        repeat (6) step();
        chk("bp_one_more", 32'(acc_log.size()), 32'd1);

        // Branch with two outstanding and one queued entry
        bus_ready = 1'b0;
        flush_i = 1'b1; new_pc_i = 32'h0000_3000;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        repeat (2) step();
        chk("br_setup_valid", 32'(valid_o), 32'h1);
        resp_en = 1'b0; bus_ready = 1'b1;
        repeat (2) step();
        chk("br_setup_pending", 32'(pend_q.size()), 32'd2);
        bus_ready = 1'b0;
        branch_flag_i = 1'b1; branch_to_addr_i = 32'h8000_1000;
        step();
        chk("br_queue_cleared", 32'(valid_o), 32'h0);
        pop_log.delete();
        resp_en = 1'b1; bus_ready = 1'b1; ready_i = 1'b1;
        repeat (10) step();
        chk("br_first_pc", first_pop_pc(), 32'h8000_1000);

        // Flush has priority over branch
        flush_i = 1'b1; new_pc_i = 32'hBFC0_0380;
        branch_flag_i = 1'b1; branch_to_addr_i = 32'h0000_1000;
        step();
        acc_log.delete();
        repeat (6) step();
        chk("prio_first_addr", first_acc(), 32'hBFC0_0380);

        // Misaligned target: one adel entry, then halted until a redirect
        branch_flag_i = 1'b1; branch_to_addr_i = 32'h8000_0002;
        step();
        req_seen = 0;
        pop_log.delete();
        repeat (10) step();
        chk("adel_no_req", 32'(req_seen), 32'd0);
        chk("adel_entries", 32'(pop_log.size()), 32'd1);
        chk("adel_flag", (pop_log.size() > 0) ? 32'(pop_log[0].adel) : 32'hDEAD_DEAD, 32'h1);
        chk("adel_pc", first_pop_pc(), 32'h8000_0002);
        chk("adel_inst", (pop_log.size() > 0) ? pop_log[0].inst : 32'hDEAD_DEAD, 32'h0);
        chk("adel_then_empty", 32'(valid_o), 32'h0);
        flush_i = 1'b1; new_pc_i = 32'hBFC0_0380;
        step();
        acc_log.delete();
        repeat (6) step();
        chk("adel_resume", first_acc(), 32'hBFC0_0380);

        // Asynchronous reset with a full queue
        ready_i = 1'b0;
        repeat (10) step();
        chk("pre_rst_valid", 32'(valid_o), 32'h1);
        rst_i = 1'b0;
        #2;
        chk("async_rst_valid", 32'(valid_o), 32'h0);
        chk("async_rst_req", 32'(inst_req_o), 32'h0);
        chk("async_rst_pc", pc_o, 32'h0);
        inst_data_ok_i = 1'b0;
        inst_addr_ok_i = 1'b0;
        pend_q.delete();
        sb_q.delete();
        exp_pc = RST_PC;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        acc_log.delete();
        ready_i = 1'b1;
        repeat (8) step();
        chk("restart_addr", first_acc(), RST_PC);

        // Drain everything still owed to decode
        bus_ready = 1'b0;
        repeat (6) step();
        chk("drained_sb", 32'(sb_q.size()), 32'd0);
        chk("drained_valid", 32'(valid_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-PC fetch stage: generates sequential PCs and keeps up to MAX_OUTSTANDING requests in flight on an SRAM-like instruction bus.
- Buffers returned instructions with their PCs in a FIFO_DEPTH-entry queue.
- Delivers instructions to decode with a valid/ready handshake.
- Handles flush and branch redirects by dropping in-flight responses, and flags misaligned fetch addresses.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction queue entries (power of two, ≥2)
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered bus requests (≤FIFO_DEPTH)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  exception/ERET redirect
- new_pc_i  in  32  flush target
- branch_flag_i  in  1  branch redirect
- branch_to_addr_i  in  32  branch target
- inst_req_o  out  1  bus request
- inst_addr_o  out  32  bus address
- inst_addr_ok_i  in  1  request accepted this cycle
- inst_data_ok_i  in  1  response valid this cycle
- inst_rdata_i  in  32  response data
- valid_o  out  1  queue head valid
- ready_i  in  1  decode accepts head
- pc_o  out  32  head PC
- inst_o  out  32  head instruction
- adel_o  out  1  head is a misaligned-fetch exception entry

Behaviour:
- Reset state (async, rst_i=0): fetch_pc=RESET_PC, outstanding=0, discard=0, queue empty, halted=0. Outputs: valid_o=0, inst_req_o=0, adel_o=0, pc_o=0, inst_o=0.
- Request issue:
  - Credit = occupancy + outstanding.
  - inst_req_o=1 when: no redirect this cycle, halted=0, fetch_pc[1:0]==0, outstanding<MAX_OUTSTANDING, and credit<FIFO_DEPTH.
  - inst_addr_o=fetch_pc.
  - Acceptance is inst_req_o && inst_addr_ok_i in the same cycle. On acceptance: fetch_pc+=4 (wraps modulo 2^32) and outstanding+=1.
  - inst_req_o may drop without acceptance.
- Response handling:
  - inst_data_ok_i decrements outstanding.
  - If discard>0: discard-=1 and the data is dropped.
  - Otherwise push {issue PC, rdata, adel=0}. The issue PC is tracked in a MAX_OUTSTANDING-deep PC shadow queue in issue order.
  - The credit rule guarantees a push never meets a full queue. If it does, it is an assertion failure.
- Output side:
  - valid_o = queue not empty. pc_o, inst_o and adel_o come from the head; they are 0 when empty.
  - The head pops on valid_o && ready_i.
  - Push and pop in the same cycle are allowed, including when the queue is full. Zero-latency bypass is not allowed: a response is visible on valid_o the cycle after inst_data_ok_i.
- Misaligned fetch:
  - If fetch_pc[1:0]!=0, no bus request is made.
  - Once outstanding==0 and discard==0 and the queue is not full, push {fetch_pc, 32'h0, adel=1} and set halted=1.
  - Issue stays halted until the next redirect.
- Redirect:
  - flush_i has priority over branch_flag_i.
  - Effects in the same cycle:
    - fetch_pc ← target
    - queue cleared; any same-cycle push or pop is ignored
    - halted ← 0
    - inst_req_o forced 0
    - discard ← outstanding + (inst_data_ok_i ? -1 : 0), which also covers pending discards
    - a same-cycle data_ok is itself dropped
  - Fetch at the target starts the next cycle. Back-to-back redirects re-accumulate discard correctly.
- Counter widths: occupancy $clog2(FIFO_DEPTH+1); outstanding and discard $clog2(MAX_OUTSTANDING+1); no overflow is reachable.
- Reset mid-operation: all state returns to the reset values immediately. In-flight responses arriving after reset release are not tracked; the bus must be reset together with this block.

Decomposition:
- Shared package (cpu_defs_pkg) holds:
  - fetch_entry_t {pc[31:0], inst[31:0], adel}
  - RESET_PC_DEFAULT
  - INST_BYTES=4
- One sub-module: fetch_fifo, a generic FIFO_DEPTH sync FIFO of fetch_entry_t with push/pop/clear/full/empty/count, async active-low reset.
- PC shadow queue reuses fetch_fifo with depth MAX_OUTSTANDING.

Test Plan:
- Reset release, addr_ok=1 every cycle, data_ok 1 cycle later, ready_i=1 → addresses BFC00000, BFC00004, BFC00008 issued back-to-back; valid_o with matching pc_o/inst_o from cycle 3.
- ready_i=0, bus always ready, FIFO_DEPTH=4 → exactly 4 requests accepted, inst_req_o then held 0; one pop → exactly one new request.
- Two requests outstanding, branch_flag_i=1 to 0x80001000 with queue holding 1 entry → queue empty next cycle; the next 2 data_ok responses dropped; first valid_o shows pc_o=0x80001000.
- flush_i and branch_flag_i asserted together (new_pc_i=0xBFC00380, branch 0x1000) → fetch resumes at 0xBFC00380.
- Branch to 0x80000002 → no bus request; one entry adel_o=1, pc_o=0x80000002, inst_o=0; no further entries until a flush to 0xBFC00380 resumes fetch.
- Assert rst_i=0 with queue full and 2 outstanding → valid_o=0 and inst_req_o=0 immediately (asynchronously); fetch restarts at RESET_PC.
